mem_bist_ctrl: RTL and testbench

//  Self-test sequencer for the 32x8 synchronous memory. On start, owns the memory

---
 rtl/mem_bist_pkg.sv | 30 +++
 rtl/mem_bist_if.sv | 20 ++
 rtl/mem_bist_chk.sv | 89 ++++++++
 rtl/mem_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory self-test sequencer.
// Optional feature macro: MEM_BIST_FAIL_LOG_EN (first-miscompare capture).
package mem_bist_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_WR  = 3'd1,
    CLR_RD  = 3'd2,
    CLR_DRN = 3'd3,
    DA_WR   = 3'd4,
    DA_RD   = 3'd5,
    DA_DRN  = 3'd6,
    DONE    = 3'd7
  } bist_state_t;

  typedef enum logic {
    PH_CLR = 1'b0,
    PH_DA  = 1'b1
  } bist_phase_t;

  // Test pattern for a location; callers truncate to their data width.
  function automatic logic [31:0] pattern(input bist_phase_t phase, input logic [31:0] addr);
    return (phase == PH_DA) ? addr : 32'd0;
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Memory bus between the self-test sequencer (master) and the 32x8 memory (slave).
// Optional feature macro: MEM_BIST_FAIL_LOG_EN (not used here).
//
// Strobe semantics: there is no ready; the memory accepts every strobe. A cycle with
// write=1 stores data_in at addr. A cycle with read=1 presents addr, and data_out holds
// that location's data RD_LAT cycles later. read and write are never both 1, and addr /
// data_in are 0 in any cycle where neither strobe is asserted.
interface mem_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output read, write, addr, data_in, input data_out);
  modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_bist_chk.sv
// Read-data checker: delays expected data by the memory read latency, compares
// against data_out, keeps a saturating miscompare count.
// Optional feature macro: MEM_BIST_FAIL_LOG_EN adds first-miscompare capture.
module mem_bist_chk
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              flush,
  input  logic              chk_vld,
  input  logic [DATA_W-1:0] chk_exp,
  input  logic [DATA_W-1:0] data_out,
`ifdef MEM_BIST_FAIL_LOG_EN
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              fail_vld,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
`endif
  output logic [7:0]        err_cnt
);

  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] exp_pipe [RD_LAT];
  logic              miss;

  // A discarded (flushed) check never counts, even if its data is on the bus now.
  assign miss = vld_pipe[RD_LAT-1] && (data_out != exp_pipe[RD_LAT-1]) && !flush;

  // Expected-data pipeline, aligned with the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int j = 0; j < RD_LAT; j++) exp_pipe[j] <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= chk_vld;
      exp_pipe[0] <= chk_exp;
      for (int j = 1; j < RD_LAT; j++) begin
        vld_pipe[j] <= vld_pipe[j-1];
        exp_pipe[j] <= exp_pipe[j-1];
      end
    end
  end

  // Saturating miscompare counter, zeroed when a new test is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= 8'd0;
    else if (clear)                     err_cnt <= 8'd0;
    else if (miss && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end

`ifdef MEM_BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];

  // Address pipeline so a miscompare can be tied back to its location.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < RD_LAT; j++) addr_pipe[j] <= '0;
    end else begin
      addr_pipe[0] <= chk_addr;
      for (int j = 1; j < RD_LAT; j++) addr_pipe[j] <= addr_pipe[j-1];
    end
  end

  // Capture only the first miscompare since the last launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (miss && !fail_vld) begin
      fail_vld  <= 1'b1;
      fail_addr <= addr_pipe[RD_LAT-1];
      fail_data <= data_out;
    end
  end
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory self-test sequencer: Clear test then Data=Address test over every location,
// reporting a saturating miscompare count and pass/fail.
// Optional feature macro: MEM_BIST_FAIL_LOG_EN adds fail_vld/fail_addr/fail_data.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
`ifdef MEM_BIST_FAIL_LOG_EN
  output logic              fail_vld,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
`endif
  output bist_state_t       state,
  mem_bist_if.master        mem
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_DRN  = ADDR_W'(RD_LAT - 1);

  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pass_q;
  logic              rd, wr;
  bist_phase_t       phase;
  logic [DATA_W-1:0] pat;
  logic              launch, quit;

  // Abort beats start in IDLE; abort elsewhere drops the run without a done pulse.
  assign launch = (state_q == IDLE) && start && !abort;
  assign quit   = (state_q != IDLE) && abort;

  // State and location/drain counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, counter and strobes. The counter walks locations in *_WR/*_RD and
  // counts drain cycles in *_DRN, restarting at 0 on every phase change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd      = 1'b0;
    wr      = 1'b0;
    phase   = PH_CLR;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = CLR_WR;
          idx_d   = '0;
        end
      end
      CLR_WR, DA_WR: begin
        wr    = 1'b1;
        phase = (state_q == DA_WR) ? PH_DA : PH_CLR;
        if (idx_q == LAST_ADDR) begin
          state_d = (state_q == DA_WR) ? DA_RD : CLR_RD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CLR_RD, DA_RD: begin
        rd    = 1'b1;
        phase = (state_q == DA_RD) ? PH_DA : PH_CLR;
        if (idx_q == LAST_ADDR) begin
          state_d = (state_q == DA_RD) ? DA_DRN : CLR_DRN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CLR_DRN, DA_DRN: begin
        if (idx_q == LAST_DRN) begin
          state_d = (state_q == DA_DRN) ? DONE : DA_WR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (quit) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  assign pat         = DATA_W'(pattern(phase, 32'(idx_q)));
  assign mem.read    = rd;
  assign mem.write   = wr;
  assign mem.addr    = (rd || wr) ? idx_q : '0;
  assign mem.data_in = wr ? pat : '0;

  // Pass verdict latched on the done cycle, cleared on launch, kept across abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pass_q <= 1'b0;
    else if (launch)            pass_q <= 1'b0;
    else if (state_q == DONE)   pass_q <= (err_cnt == 8'd0);
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign pass  = (state_q == DONE) ? (err_cnt == 8'd0) : pass_q;
  assign state = state_q;

  mem_bist_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (launch),
    .flush    (quit),
    .chk_vld  (rd),
    .chk_exp  (pat),
    .data_out (mem.data_out),
`ifdef MEM_BIST_FAIL_LOG_EN
    .chk_addr (idx_q),
    .fail_vld (fail_vld),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
`endif
    .err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: faulty-memory model, expected bus-cycle queue and
// miscompare-count model derived from the test algorithm.
// Optional feature macro: MEM_BIST_FAIL_LOG_EN enables first-fail capture checks.
module tb_mem_bist_ctrl;
  import mem_bist_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ADDR_W2 = 8;
  localparam int DEPTH2  = 1 << ADDR_W2;
  localparam int TW      = 4 + ADDR_W + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic busy, done, pass, busy2, done2, pass2;
  logic [7:0] err_cnt, err_cnt2;
  bist_state_t state, state2;

  always #5 clk = ~clk;

  mem_bist_if #(.ADDR_W(ADDR_W),  .DATA_W(DATA_W)) mem1 ();
  mem_bist_if #(.ADDR_W(ADDR_W2), .DATA_W(DATA_W)) mem2 ();

`ifdef MEM_BIST_FAIL_LOG_EN
  logic fail_vld, fail_vld2;
  logic [ADDR_W-1:0]  fail_addr;
  logic [ADDR_W2-1:0] fail_addr2;
  logic [DATA_W-1:0]  fail_data, fail_data2;
`endif

  mem_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
`ifdef MEM_BIST_FAIL_LOG_EN
    .fail_vld(fail_vld), .fail_addr(fail_addr), .fail_data(fail_data),
`endif
    .state(state), .mem(mem1.master)
  );

  // Large-depth instance: enough reads to drive the counter past saturation.
  mem_bist_ctrl #(.ADDR_W(ADDR_W2), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
`ifdef MEM_BIST_FAIL_LOG_EN
    .fail_vld(fail_vld2), .fail_addr(fail_addr2), .fail_data(fail_data2),
`endif
    .state(state2), .mem(mem2.master)
  );

  assign mem2.data_out = 8'hFF;

  // ---------------- memory model with fault injection ----------------
  int mode = 0;  // 0 good, 1 addr 5 bit 0 stuck-at-1, 2 always 8'hFF, 3 random stuck bits
  logic [DATA_W-1:0] mem_arr [DEPTH];
  logic [DATA_W-1:0] and_m   [DEPTH];
  logic [DATA_W-1:0] or_m    [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  function automatic logic [DATA_W-1:0] faulty(input int a, input logic [DATA_W-1:0] v);
    case (mode)
      1:       return (a == 5) ? (v | 8'h01) : v;
      2:       return 8'hFF;
      3:       return (v & ~and_m[a]) | or_m[a];
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem1.write) mem_arr[mem1.addr] <= mem1.data_in;
    rd_pipe[0] <= mem1.read ? faulty(int'(mem1.addr), mem_arr[mem1.addr]) : '0;
    for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
  end
  assign mem1.data_out = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Miscompares among the first n_chk reads (Clear reads of 0..DEPTH-1, then
  // Data=Address reads), saturating at 255.
  function automatic int exp_errs(input int n_chk);
    int n;
    int a;
    logic [DATA_W-1:0] pat;
    n = 0;
    for (int k = 0; k < n_chk; k++) begin
      a   = k % DEPTH;
      pat = (k < DEPTH) ? '0 : DATA_W'(a);
      if (faulty(a, pat) != pat) n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Per-cycle bus picture {busy, done, read, write, addr, data_in} from the first
  // write cycle through the done cycle.
  task automatic build_seq();
    logic [DATA_W-1:0] pat;
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        pat = (ph == 0) ? '0 : DATA_W'(a);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, ADDR_W'(a), pat});
      end
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, ADDR_W'(a), DATA_W'(0)});
      for (int d = 0; d < RD_LAT; d++)
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(0), DATA_W'(0)});
    end
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, ADDR_W'(0), DATA_W'(0)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_full(input int md, input int mid_start, input int rst_at);
    int idx;
    int exp_e;
    logic [TW-1:0] exp_t, got_t;
    logic [DATA_W-1:0] obs_d;
    mode  = md;
    exp_e = exp_errs(2 * DEPTH);
    build_seq();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_async", {busy, done, pass, err_cnt, mem1.read, mem1.write,
                            mem1.addr, mem1.data_in}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      exp_t = exp_q.pop_front();
      obs_d = mem1.read ? '0 : mem1.data_in;  // write data is a don't-care during reads
      got_t = {busy, done, mem1.read, mem1.write, mem1.addr, obs_d};
      check("bus_seq", got_t, exp_t);
      if (exp_t[TW-2]) begin
        check("err_at_done", err_cnt, exp_e);
        check("pass_at_done", pass, (exp_e == 0));
`ifdef MEM_BIST_FAIL_LOG_EN
        check("fail_vld", fail_vld, (exp_e != 0));
`endif
      end
      if (idx == mid_start) start = 1'b1;
      @(negedge clk); start = 1'b0;
      idx++;
    end
    check("idle_after", {busy, done, mem1.read, mem1.write}, 32'd0);
    check("pass_hold", pass, (exp_e == 0));
    check("err_hold", err_cnt, exp_e);
  endtask

  task automatic run_abort();
    int exp_e;
    mode  = 1;
    // Reads of Clear addresses whose check completed before the abort edge.
    exp_e = exp_errs(39 - (DEPTH + 1) - RD_LAT + 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    check("abort_pre_clr_rd", {busy, mem1.read, mem1.write}, 32'b110);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_idle", {busy, done, mem1.read, mem1.write, mem1.addr}, 32'd0);
    check("abort_err_keep", err_cnt, exp_e);
    check("abort_pass_keep", pass, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_done", {busy, done}, 32'd0);
    end
    // abort and start together in IDLE: stay idle, counters untouched
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 1'b0);
    @(negedge clk);
    check("abort_start_err", err_cnt, exp_e);
  endtask

  task automatic run_sat();
    int c;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    c = 1;
    while (!done2 && c < 4 * DEPTH2 + 2 * RD_LAT + 20) begin
      if (c == 10)
        check("sat_write9", {mem2.read, mem2.write, mem2.addr, mem2.data_in}, {2'b01, 8'd9, 8'd0});
      if (c == DEPTH2 + 4)
        check("sat_read3", {mem2.read, mem2.write, mem2.addr}, {2'b10, 8'd3});
      if (c == DEPTH2 + 2 + RD_LAT + 99)
        check("sat_count_100", err_cnt2, 100);
      if (c == 2 * DEPTH2 + RD_LAT + 20)
        check("sat_after_clear", err_cnt2, 255);
      @(negedge clk);
      c++;
    end
    check("sat_done_cycle", c, 1 + 4 * DEPTH2 + 2 * RD_LAT);
    check("sat_err", err_cnt2, 255);
    check("sat_pass", pass2, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_outputs", {busy, done, pass, err_cnt, mem1.read, mem1.write,
                          mem1.addr, mem1.data_in}, 32'd0);
    check("rst_state", state, IDLE);
    check("rst_state2", {state2, busy2, done2, pass2, err_cnt2}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_no_strobe", {busy, mem1.read, mem1.write}, 32'd0);
    end

    run_full(0, -1, -1);
    run_full(1, -1, -1);
`ifdef MEM_BIST_FAIL_LOG_EN
    check("fail_addr", fail_addr, 5);
    check("fail_data", fail_data, 8'h01);
`endif
    run_full(2, -1, -1);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 9) < 2) begin
          and_m[a] = DATA_W'($urandom);
          or_m[a]  = DATA_W'($urandom);
        end else begin
          and_m[a] = '0;
          or_m[a]  = '0;
        end
      end
      run_full(3, -1, -1);
    end

    run_abort();
    run_full(0, -1, -1);

    run_full(0, 50, 2 * DEPTH + RD_LAT + 10);
    check("post_rst_idle", {busy, pass, err_cnt}, 32'd0);
    run_full(0, -1, -1);

    run_sat();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
